// File: rtl/apb_regfile_ws.sv
// rtl/apb_regfile_ws.sv - APB4 slave register file with byte strobes, wait states, RO mask
module apb_regfile_ws #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 16,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    WAIT_STATES = 0,
  parameter logic [DEPTH-1:0]      RO_MASK     = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic                        pclk,
  input  logic                        presetn,
  input  logic [ADDR_WIDTH-1:0]       paddr,
  input  logic                        psel,
  input  logic                        penable,
  input  logic                        pwrite,
  input  logic [DATA_WIDTH-1:0]       pwdata,
  input  logic [DATA_WIDTH/8-1:0]     pstrb,
  output logic [DATA_WIDTH-1:0]       prdata,
  output logic                        pready,
  output logic                        pslverr,
  output logic [DEPTH*DATA_WIDTH-1:0] regs_o
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW  = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(DEPTH * NB);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state_q, state_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];

  logic [IW-1:0] addr_idx;
  logic          err_addr;
  logic          err_ro;

  assign addr_idx = paddr[LSB +: IW];
  assign err_addr = (paddr[LSB-1:0] != '0) || (paddr >= SPAN);
  assign err_ro   = pwrite && RO_MASK[addr_idx];

  assign pready  = (state_q == ACCESS) && (wcnt_q == 4'd0);
  assign pslverr = pready && err_q;
  assign prdata  = prdata_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    idx_d    = idx_q;
    write_d  = write_q;
    err_d    = err_q;
    prdata_d = prdata_q;
    regs_d   = regs_q;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          idx_d   = addr_idx;
          write_d = pwrite;
          err_d   = err_addr || err_ro;
          wcnt_d  = 4'(WAIT_STATES);
          if (!pwrite) begin
            prdata_d = err_addr ? '0 : regs_q[addr_idx];
          end
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // Dropping psel mid-transfer abandons it without touching the registers.
        if (!psel) begin
          state_d = IDLE;
        end else if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
        end else if (penable) begin
          state_d = IDLE;
          if (write_q && !err_q) begin
            for (int b = 0; b < NB; b++) begin
              if (pstrb[b]) begin
                regs_d[idx_q][b*8 +: 8] = pwdata[b*8 +: 8];
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q  <= IDLE;
      wcnt_q   <= 4'd0;
      idx_q    <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      prdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      idx_q    <= idx_d;
      write_q  <= write_d;
      err_q    <= err_d;
      prdata_q <= prdata_d;
      regs_q   <= regs_d;
    end
  end

endmodule

// File: tb/tb_apb_regfile_ws.sv
// tb/tb_apb_regfile_ws.sv - directed bench for apb_regfile_ws, two instances (2 and 0 wait states)
module tb_apb_regfile_ws;

  logic        pclk = 1'b0;
  logic        presetn, psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  int          cur;

  logic         psel0, psel1;
  logic [31:0]  prdata0, prdata1;
  logic         pready0, pready1, pslverr0, pslverr1;
  logic [511:0] regs0, regs1;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  logic [31:0] mdl [2][16];

  always #5 pclk = ~pclk;

  assign psel0 = psel && (cur == 0);
  assign psel1 = psel && (cur == 1);

  apb_regfile_ws #(.DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(32), .WAIT_STATES(2),
                   .RO_MASK(16'h8000), .RESET_VAL(32'h0)) dut (
    .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel0), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata0), .pready(pready0),
    .pslverr(pslverr0), .regs_o(regs0));

  apb_regfile_ws #(.DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(32), .WAIT_STATES(0),
                   .RO_MASK(16'h8000), .RESET_VAL(32'h0)) dut_nw (
    .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel1), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata1), .pready(pready1),
    .pslverr(pslverr1), .regs_o(regs1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic int ws(input int w);
    return (w == 0) ? 2 : 0;
  endfunction

  function automatic bit m_err(input bit wr, input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'd64) || (wr && a[5:2] == 4'd15);
  endfunction

  function automatic logic cur_pready();
    return (cur == 0) ? pready0 : pready1;
  endfunction

  task automatic mdl_reset();
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 16; i++) mdl[w][i] = 32'h0;
  endtask

  // Register image of both instances must track the model on every cycle.
  always @(negedge pclk) begin
    if (chk_en) begin
      for (int w = 0; w < 2; w++) begin
        logic [511:0] ef;
        logic [511:0] act;
        for (int i = 0; i < 16; i++) ef[i*32 +: 32] = mdl[w][i];
        act = (w == 0) ? regs0 : regs1;
        total++;
        if (act !== ef) begin
          bad++;
          $display("FAIL regs_o[dut%0d]: got %h want %h", w, act, ef);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the completion edge so the next
  // call issues its setup in the very next cycle.
  task automatic xfer(input int w, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output bit er, output int cyc);
    bit          e;
    logic [31:0] exp;
    cur = w;
    e   = m_err(wr, a);
    exp = (e || wr) ? 32'h0 : mdl[w][a[5:2]];
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(posedge pclk); #1;
    penable = 1'b1;
    cyc = 1;
    @(negedge pclk);
    while (!cur_pready() && cyc < 20) begin
      @(posedge pclk); #1;
      cyc++;
      @(negedge pclk);
    end
    if (!cur_pready()) begin
      total++; bad++;
      $display("FAIL timeout dut%0d addr %h: got no pready want pready", w, a);
      rd = 32'h0; er = 1'b1;
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
      return;
    end
    rd = (w == 0) ? prdata0 : prdata1;
    er = (w == 0) ? pslverr0 : pslverr1;
    check($sformatf("pslverr dut%0d %s %h", w, wr ? "wr" : "rd", a), {31'b0, er}, {31'b0, e});
    if (!wr) check($sformatf("prdata dut%0d %h", w, a), rd, exp);
    check($sformatf("latency dut%0d %h", w, a), cyc, ws(w) + 1);
    @(posedge pclk);
    if (wr && !e)
      for (int b = 0; b < 4; b++)
        if (s[b]) mdl[w][a[5:2]][b*8 +: 8] = d[b*8 +: 8];
    #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    bit          er;
    int          cyc;
    cur = 0; presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0; pstrb = 4'h0;
    mdl_reset();
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    check("reset pready0", {31'b0, pready0}, 32'h0);
    check("reset pready1", {31'b0, pready1}, 32'h0);
    check("reset pslverr0", {31'b0, pslverr0}, 32'h0);
    check("reset prdata0", prdata0, 32'h0);
    check("reset regs0 low", regs0[31:0], 32'h0);
    chk_en = 1'b1;
    @(posedge pclk); #1;
    presetn = 1'b1;

    // 1: read after reset, three ACCESS cycles
    xfer(0, 0, 32'h08, 32'h0, 4'h0, rd, er, cyc);
    check("t1 rdata", rd, 32'h0);
    check("t1 cycles", cyc, 3);

    // 2: full then partial-strobe write
    xfer(0, 1, 32'h04, 32'hDEADBEEF, 4'hF, rd, er, cyc);
    xfer(0, 1, 32'h04, 32'h11223344, 4'b0101, rd, er, cyc);
    check("t2 regs_o[63:32]", regs0[63:32], 32'hDE22BE44);
    check("t2 model pin", mdl[0][1], 32'hDE22BE44);
    xfer(0, 0, 32'h04, 32'h0, 4'h0, rd, er, cyc);
    check("t2 rdata", rd, 32'hDE22BE44);

    // 3: read-only register 15
    xfer(0, 1, 32'h3C, 32'h1, 4'hF, rd, er, cyc);
    check("t3 wr err", {31'b0, er}, 32'h1);
    xfer(0, 0, 32'h3C, 32'h0, 4'h0, rd, er, cyc);
    check("t3 rd data", rd, 32'h0);
    check("t3 rd err", {31'b0, er}, 32'h0);

    // 4: out of range and misaligned reads
    xfer(0, 0, 32'h40, 32'h0, 4'h0, rd, er, cyc);
    check("t4 range err", {31'b0, er}, 32'h1);
    check("t4 range data", rd, 32'h0);
    xfer(0, 0, 32'h05, 32'h0, 4'h0, rd, er, cyc);
    check("t4 misalign err", {31'b0, er}, 32'h1);
    check("t4 misalign data", rd, 32'h0);

    // 5a: abort by dropping psel in the second ACCESS cycle
    cur = 0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'hA5A5A5A5; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    check("t5 access1 pready", {31'b0, pready0}, 32'h0);
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    xfer(0, 0, 32'h00, 32'h0, 4'h0, rd, er, cyc);
    check("t5 abort rdata", rd, 32'h0);

    // 5b: reset during an ACCESS write
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'hA5A5A5A5; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1; presetn = 1'b0;
    @(posedge pclk);
    mdl_reset();
    @(negedge pclk);
    check("t5 reset pready", {31'b0, pready0}, 32'h0);
    @(posedge pclk); #1;
    presetn = 1'b1; psel = 1'b0; penable = 1'b0;
    xfer(0, 0, 32'h00, 32'h0, 4'h0, rd, er, cyc);
    check("t5 reset rdata", rd, 32'h0);
    xfer(0, 0, 32'h04, 32'h0, 4'h0, rd, er, cyc);
    check("t5 reg1 cleared", rd, 32'h0);

    // 6: back-to-back write/read pairs on both wait-state settings
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 8; i++) begin
        logic [31:0] v;
        v = 32'hC0DE0000 | (w << 8) | i;
        xfer(w, 1, i * 4, v, 4'hF, rd, er, cyc);
        xfer(w, 0, i * 4, 32'h0, 4'h0, rd, er, cyc);
        check($sformatf("t6 dut%0d reg%0d", w, i), rd, v);
        check($sformatf("t6 dut%0d err%0d", w, i), {31'b0, er}, 32'h0);
        if (w == 1) check($sformatf("t6 nw cycles%0d", i), cyc + 1, 2);
      end
    end

    @(posedge pclk); #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
